// File: rtl/clk_div_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : clk_div_pkg
//  Description : Shared widths, reset ratio and helpers for the divider bank.
//  Revision    : 1.0  initial release
// ============================================================================
package clk_div_pkg;

    localparam int C_CNT_W       = 16;
    localparam int C_DEFAULT_DIV = 2500;

    typedef logic [C_CNT_W-1:0] div_t;

    // Channel-select width; a single-channel bank still needs one select bit.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/clk_div_chan.sv
`default_nettype none
// ============================================================================
//  Module      : clk_div_chan
//  Description : One divider channel: phase counter, shadow/active ratio,
//                boundary-aligned ratio apply and registered clk/tick outputs.
//  Revision    : 1.0  initial release
// ============================================================================
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int CNT_W       = C_CNT_W,
    parameter int DEFAULT_DIV = C_DEFAULT_DIV
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_wr,
    input  logic [CNT_W-1:0] i_val,
    output logic             o_clk_out,
    output logic             o_tick,
    output logic             o_pending
);

    localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_RST_DIV = CNT_W'(DEFAULT_DIV);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_act;
    logic [CNT_W-1:0] r_shd;
    logic             r_pend;
    logic             r_clk_out;
    logic             r_tick;

    logic             w_run;
    logic             w_last;
    logic             w_apply;
    logic             w_clk_next;

    always_comb begin
        w_run      = i_en && (r_act != '0);
        // >= rather than == keeps the counter bounded whatever the history.
        w_last     = (r_cnt >= (r_act - C_ONE));
        w_apply    = r_pend && (!w_run || w_last);
        w_clk_next = (r_act == C_ONE) || (r_cnt < (r_act >> 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_act     <= C_RST_DIV;
            r_shd     <= C_RST_DIV;
            r_pend    <= 1'b0;
            r_clk_out <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            if (w_run) begin
                r_clk_out <= w_clk_next;
                r_tick    <= w_last;
                r_cnt     <= w_last ? '0 : (r_cnt + C_ONE);
            end else begin
                r_clk_out <= 1'b0;
                r_tick    <= 1'b0;
                r_cnt     <= '0;
            end

            if (w_apply) begin
                r_act <= r_shd;
            end

            // A write landing on the apply edge survives as the next pending ratio.
            if (i_wr) begin
                r_shd  <= i_val;
                r_pend <= 1'b1;
            end else if (w_apply) begin
                r_pend <= 1'b0;
            end
        end
    end

    assign o_clk_out = r_clk_out;
    assign o_tick    = r_tick;
    assign o_pending = r_pend;

endmodule
`default_nettype wire

// File: rtl/clk_divider_bank.sv
`default_nettype none
// ============================================================================
//  Module      : clk_divider_bank
//  Description : NUM_CH programmable divided clocks / tick strobes plus a
//                stretched, synchronously released downstream reset.
//  Revision    : 1.0  initial release
// ============================================================================
module clk_divider_bank
    import clk_div_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = C_CNT_W,
    parameter int DEFAULT_DIV = C_DEFAULT_DIV,
    parameter int RST_STRETCH = 4
) (
    input  logic                         clk,
    input  logic                         clk_rst,
    input  logic [NUM_CH-1:0]            ch_en,
    input  logic                         div_wr,
    input  logic [sel_width(NUM_CH)-1:0] div_ch,
    input  logic [CNT_W-1:0]             div_val,
    output logic [NUM_CH-1:0]            clk_out,
    output logic [NUM_CH-1:0]            tick,
    output logic [NUM_CH-1:0]            pending,
    output logic                         clk_rst_out
);

    localparam int                 C_SEL_W    = sel_width(NUM_CH);
    localparam int                 C_STR_W    = $clog2(RST_STRETCH + 1);
    localparam logic [C_STR_W-1:0] C_STR_LOAD = C_STR_W'(RST_STRETCH);
    localparam logic [C_STR_W-1:0] C_STR_ONE  = C_STR_W'(1);

    logic [NUM_CH-1:0]  w_wr;
    logic [C_STR_W-1:0] r_str_cnt;
    logic               r_rst_out;

    // Select values at or beyond NUM_CH match no channel, so such writes vanish.
    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
            assign w_wr[g] = div_wr && (div_ch == C_SEL_W'(g));

            clk_div_chan #(
                .CNT_W       (CNT_W),
                .DEFAULT_DIV (DEFAULT_DIV)
            ) u_chan (
                .clk       (clk),
                .rst       (clk_rst),
                .i_en      (ch_en[g]),
                .i_wr      (w_wr[g]),
                .i_val     (div_val),
                .o_clk_out (clk_out[g]),
                .o_tick    (tick[g]),
                .o_pending (pending[g])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge clk_rst) begin
        if (clk_rst) begin
            r_str_cnt <= C_STR_LOAD;
            r_rst_out <= 1'b1;
        end else if (r_str_cnt != '0) begin
            r_str_cnt <= r_str_cnt - C_STR_ONE;
            if (r_str_cnt == C_STR_ONE) begin
                r_rst_out <= 1'b0;
            end
        end
    end

    assign clk_rst_out = r_rst_out;

endmodule
`default_nettype wire

// File: doc/clk_divider_bank.md
# clk_divider_bank

Multi-channel programmable clock-enable / divided-clock generator, successor to the single fixed-ratio `clk_divide`. Produces `NUM_CH` independent divided clocks and one-cycle tick strobes from the system clock, with run-time divide ratios that change glitch-free at period boundaries. It also produces a stretched, synchronously released reset for downstream logic. It sits at the top of the Avalon-MM master clocking path and feeds sample-rate strobes to the LPC datapath.

## Interface
- `NUM_CH`, 4, number of divider channels (1..16)
- `CNT_W`, 16, divide-ratio and counter width
- `DEFAULT_DIV`, 2500, divide ratio loaded into every channel at reset (must be ≥2)
- `RST_STRETCH`, 4, cycles `clk_rst_out` stays high after `clk_rst` deasserts (≥1)

- `clk`  in  1  system clock
- `clk_rst`  in  1  reset, asynchronous, active-high
- `ch_en`  in  NUM_CH  per-channel run enable
- `div_wr`  in  1  one-cycle write strobe for a new ratio
- `div_ch`  in  $clog2(NUM_CH) (min 1)  target channel of `div_wr`
- `div_val`  in  CNT_W  new divide ratio N
- `clk_out`  out  NUM_CH  divided clock per channel (registered)
- `tick`  out  NUM_CH  one-cycle strobe on last cycle of each period
- `pending`  out  NUM_CH  ratio written but not yet applied
- `clk_rst_out`  out  1  stretched reset, async assert, sync release

## Operation
- Per channel: counter `cnt` (CNT_W), active ratio `act`, shadow ratio `shd`, `pending` flag.
- Running (`ch_en`=1, `act`≥1): `cnt` counts 0..act-1 and wraps to 0.
- Outputs are registered against `cnt`. In the cycle where `cnt`==c: `clk_out` = (c < act>>1), and `tick` = (c == act-1).
- N=2: 50 % duty. Odd N: high floor(N/2), low ceil(N/2).
- `act`=1: `clk_out` held 1, `tick` high every cycle.
- `act`=0: channel stopped. Behaves as disabled.
- Disabled (`ch_en`=0): `cnt`=0, `clk_out`=0, `tick`=0.
  - On the first enabled cycle, `cnt`=0 and `clk_out` follows the rule above.
  - Re-enable always restarts the phase at 0.
- Ratio write: `div_wr`=1 stores `div_val` into `shd[div_ch]` and sets `pending`.
  - Running channel: `act`←`shd`, `cnt`←0 and `pending` clears on the clock edge ending a `tick` cycle. Periods are never truncated.
  - Disabled or stopped channel: applied on the next edge.
  - Multiple writes before apply: last write wins.
  - A write coinciding with the apply edge is kept as a new pending value; the old shadow value is applied.
  - `div_ch` ≥ NUM_CH: write ignored.
- Reset stretcher: counter of width $clog2(RST_STRETCH+1).
  - `clk_rst` forces `clk_rst_out`=1 asynchronously and loads the counter.
  - After deassertion it decrements once per clock. `clk_rst_out` drops on the edge where the counter reaches 0.

## Timing
- Reset values: `cnt`=0, `act`=`shd`=DEFAULT_DIV, `pending`=0, `clk_out`=0, `tick`=0, `clk_rst_out`=1.
- Output latency: one clock from `cnt` state to `clk_out`/`tick`. `ch_en` rising at edge k gives the first high `clk_out` in cycle k+1.
- Write-to-`pending` latency: 1 cycle.
- Write-to-new-period latency on a disabled channel: 1 cycle.
- Reset mid-period discards all state, including pending writes. There is no partial-period output.
- Channels are fully independent. Simultaneous ticks on all channels are allowed.
- `clk_out` is a fabric signal, not a global clock. Consumers use `tick` as a clock enable.

## Structure
- Shared package `clk_div_pkg`: `CNT_W` default, `div_t` (logic [CNT_W-1:0]), `DEFAULT_DIV` constant.
- One sub-module, `clk_div_chan`: counter, shadow/active registers, output regs, apply logic.
- Top instantiates `NUM_CH` copies via generate, decodes `div_wr`/`div_ch`, and holds the reset stretcher.

## Test plan
- Reset with `clk_rst` pulsed 1 cycle, RST_STRETCH=4 → `clk_rst_out` high asynchronously, released exactly 4 edges after deassert. All `clk_out`/`tick` are 0 until `ch_en` is set.
- ch0 enabled, DEFAULT_DIV=2500 (50 MHz clk) → `tick` every 2500 cycles (20 kHz), `clk_out` 1250 high / 1250 low; run ≥12500 cycles.
- Write N=5 to ch1 mid-period → `pending`=1 next cycle. The old period completes, then `clk_out` is 2 high / 3 low and `tick` every 5 cycles; `pending`=0 after the apply edge.
- Two writes (7 then 3) to ch2 before wrap → only N=3 is applied. A write coinciding with the apply edge leaves `pending`=1.
- N=1 on ch3 → `clk_out` constant 1 and `tick` every cycle. Then N=0 → ch3 outputs 0 with `ch_en`=1.
- `div_ch`=NUM_CH with `div_wr` → no channel changes. `clk_rst` asserted mid-period → all channels return to the reset state within the same cycle.
